// File: rtl/idli_issue_m.sv
// idli issue sequencer: sync counter, encoding-load select,
// conditional-execution tracking and multi-period stall.
module idli_issue_m #(
  parameter int COND_W  = 8,
  parameter int MULTI_W = 4
) (
  input  logic                    i_is_gck,
  input  logic                    i_is_rst,
  input  logic                    i_is_word_vld,
  input  logic                    i_is_rhs_sqi,
  input  logic [MULTI_W-1:0]      i_is_multi_cnt,
  input  logic                    i_is_cond_wr,
  input  logic [COND_W-1:0]       i_is_cond,
  input  logic [$clog2(COND_W):0] i_is_cond_len,
  input  logic                    i_is_pred,
  input  logic                    i_is_redirect,
  output logic [1:0]              o_is_ctr,
  output logic                    o_is_enc_vld,
  output logic                    o_is_cur_vld,
  output logic                    o_is_exec,
  output logic                    o_is_stall,
  output logic                    o_is_cex_act
);

  localparam int LEN_W = $clog2(COND_W) + 1;

  typedef enum logic {
    RUN,
    MULTI
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ctr_q;
  logic               cur_vld_q, cur_vld_d;
  logic               exec_q, exec_d;
  logic [COND_W-1:0]  mask_q, mask_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MULTI_W-1:0] mcnt_q, mcnt_d;

  logic               period;
  logic               commit;
  logic               in_multi;
  logic               exit_multi;
  logic               hold_multi;
  logic               go_multi;
  logic               redir;
  logic               cex_ld;
  logic               enc;
  logic [COND_W-1:0]  eff_mask;
  logic [LEN_W-1:0]   eff_len;

  always_comb begin
    period     = (ctr_q == 2'd3);
    commit     = cur_vld_q && exec_q;
    in_multi   = (state_q == MULTI);
    exit_multi = in_multi && (mcnt_q <= MULTI_W'(1));
    hold_multi = in_multi && !exit_multi;
    // The exit edge of a stall behaves like a normal RUN edge.
    redir      = (!in_multi || exit_multi) && commit
                 && i_is_redirect;
    go_multi   = !in_multi && commit && !redir
                 && (i_is_multi_cnt != '0);
    cex_ld     = !in_multi && commit && !redir
                 && i_is_cond_wr && (i_is_cond_len != '0);
    enc        = period && i_is_word_vld
                 && !(cur_vld_q && i_is_rhs_sqi)
                 && !hold_multi && !go_multi && !redir;
    eff_mask   = cex_ld ? i_is_cond : mask_q;
    eff_len    = cex_ld ? i_is_cond_len : len_q;
  end

  always_comb begin
    state_d   = (go_multi || hold_multi) ? MULTI : RUN;
    cur_vld_d = (go_multi || hold_multi) ? 1'b1 : enc;
    mcnt_d    = mcnt_q;
    exec_d    = exec_q;
    mask_d    = eff_mask;
    len_d     = eff_len;
    if (go_multi) begin
      mcnt_d = i_is_multi_cnt;
    end else if (in_multi) begin
      mcnt_d = mcnt_q - MULTI_W'(1);
    end
    if (redir) begin
      mask_d = '0;
      len_d  = '0;
    end else if (enc) begin
      if (eff_len == '0) begin
        exec_d = 1'b1;
      end else begin
        exec_d = (eff_mask[0] == i_is_pred);
        mask_d = eff_mask >> 1;
        len_d  = eff_len - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge i_is_gck) begin
    if (i_is_rst) begin
      ctr_q     <= 2'd0;
      state_q   <= RUN;
      cur_vld_q <= 1'b0;
      exec_q    <= 1'b0;
      mask_q    <= '0;
      len_q     <= '0;
      mcnt_q    <= '0;
    end else begin
      ctr_q <= ctr_q + 2'd1;
      if (period) begin
        state_q   <= state_d;
        cur_vld_q <= cur_vld_d;
        exec_q    <= exec_d;
        mask_q    <= mask_d;
        len_q     <= len_d;
        mcnt_q    <= mcnt_d;
      end
    end
  end

  assign o_is_ctr     = ctr_q;
  assign o_is_enc_vld = enc;
  assign o_is_cur_vld = cur_vld_q;
  assign o_is_exec    = cur_vld_q && exec_q;
  assign o_is_stall   = in_multi;
  assign o_is_cex_act = (len_q != '0);

endmodule

// File: tb/tb_idli_issue_m.sv
// Period-stepped vector bench for idli_issue_m with a
// scoreboard of post-edge expectations.
module tb_idli_issue_m;

  logic       clk;
  logic       rst;
  logic       word_vld;
  logic       rhs_sqi;
  logic [3:0] multi_cnt;
  logic       cond_wr;
  logic [7:0] cond;
  logic [3:0] cond_len;
  logic       pred;
  logic       redirect;
  logic [1:0] ctr;
  logic       enc_vld;
  logic       cur_vld;
  logic       exec;
  logic       stall;
  logic       cex_act;

  idli_issue_m #(.COND_W(8), .MULTI_W(4)) dut (
    .i_is_gck      (clk),
    .i_is_rst      (rst),
    .i_is_word_vld (word_vld),
    .i_is_rhs_sqi  (rhs_sqi),
    .i_is_multi_cnt(multi_cnt),
    .i_is_cond_wr  (cond_wr),
    .i_is_cond     (cond),
    .i_is_cond_len (cond_len),
    .i_is_pred     (pred),
    .i_is_redirect (redirect),
    .o_is_ctr      (ctr),
    .o_is_enc_vld  (enc_vld),
    .o_is_cur_vld  (cur_vld),
    .o_is_exec     (exec),
    .o_is_stall    (stall),
    .o_is_cex_act  (cex_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic       rhs;
    logic [3:0] multi;
    logic       cw;
    logic [7:0] cnd;
    logic [3:0] clen;
    logic       p;
    logic       rd;
    logic       e_enc;
    logic       e_cur;
    logic       e_exec;
    logic       e_stall;
    logic       e_cex;
  } vec_t;

  typedef struct {
    logic cur;
    logic ex;
    logic st;
    logic cx;
  } post_t;

  vec_t  tbl[$];
  post_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    rst_at;

  function automatic vec_t mk(
    logic w, logic rhs, logic [3:0] multi, logic cw,
    logic [7:0] cnd, logic [3:0] clen, logic p, logic rd,
    logic e_enc, logic e_cur, logic e_exec,
    logic e_stall, logic e_cex);
    vec_t t;
    t.w = w; t.rhs = rhs; t.multi = multi; t.cw = cw;
    t.cnd = cnd; t.clen = clen; t.p = p; t.rd = rd;
    t.e_enc = e_enc; t.e_cur = e_cur; t.e_exec = e_exec;
    t.e_stall = e_stall; t.e_cex = e_cex;
    return t;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp_v, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    word_vld  = t.w;
    rhs_sqi   = t.rhs;
    multi_cnt = t.multi;
    cond_wr   = t.cw;
    cond      = t.cnd;
    cond_len  = t.clen;
    pred      = t.p;
    redirect  = t.rd;
  endtask

  task automatic step(input vec_t t, input int idx);
    post_t e;
    post_t g;
    int    n;
    drive(t);
    n = 0;
    while (ctr != 2'd3 && n < 8) begin
      chk("enc_off", int'(enc_vld), 0);
      @(negedge clk);
      n++;
    end
    chk($sformatf("ctr3_%0d", idx), int'(ctr), 3);
    chk($sformatf("enc_%0d", idx), int'(enc_vld),
        int'(t.e_enc));
    e.cur = t.e_cur; e.ex = t.e_exec;
    e.st = t.e_stall; e.cx = t.e_cex;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    chk($sformatf("cur_%0d", idx), int'(cur_vld), int'(g.cur));
    chk($sformatf("exec_%0d", idx), int'(exec), int'(g.ex));
    chk($sformatf("stall_%0d", idx), int'(stall), int'(g.st));
    chk($sformatf("cex_%0d", idx), int'(cex_act), int'(g.cx));
    chk($sformatf("ctr0_%0d", idx), int'(ctr), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctr"}, int'(ctr), 0);
    chk({nm, "_enc"}, int'(enc_vld), 0);
    chk({nm, "_cur"}, int'(cur_vld), 0);
    chk({nm, "_exec"}, int'(exec), 0);
    chk({nm, "_stall"}, int'(stall), 0);
    chk({nm, "_cex"}, int'(cex_act), 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    chk("pre_rst_ctr", int'(ctr), 1);
    chk("pre_rst_stall", int'(stall), 1);
    chk("pre_rst_cex", int'(cex_act), 1);
    rst = 1'b1;
    drive(mk(0,0,0,0,8'h00,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    chk_zero("mid_rst");
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          w r mu cw cond  cl p rd  enc cur ex st cx
    tbl.push_back(mk(1,0,0,0,8'h00,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(1,0,0,0,8'h00,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(1,1,0,0,8'h00,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,8'h00,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(1,0,0,1,8'h05,3,1,0, 1,1,1,0,1));
    tbl.push_back(mk(1,0,0,0,8'h00,0,1,0, 1,1,0,0,1));
    tbl.push_back(mk(1,0,0,0,8'h00,0,1,0, 1,1,1,0,0));
    tbl.push_back(mk(1,0,0,0,8'h00,0,1,0, 1,1,1,0,0));
    tbl.push_back(mk(1,0,0,1,8'h02,2,0,0, 1,1,1,0,1));
    tbl.push_back(mk(1,0,0,1,8'h00,1,1,0, 1,1,0,0,0));
    tbl.push_back(mk(1,0,0,1,8'h00,2,1,0, 1,1,1,0,0));
    tbl.push_back(mk(1,0,0,1,8'h07,3,1,0, 1,1,1,0,1));
    tbl.push_back(mk(1,0,0,0,8'h00,0,1,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,8'h00,0,1,1, 1,1,1,0,0));
    tbl.push_back(mk(1,0,0,1,8'h02,2,1,0, 1,1,0,0,1));
    tbl.push_back(mk(1,0,3,0,8'h00,0,1,1, 1,1,1,0,0));
    tbl.push_back(mk(1,0,2,0,8'h00,0,0,0, 0,1,1,1,0));
    tbl.push_back(mk(1,0,0,0,8'h00,0,0,0, 0,1,1,1,0));
    tbl.push_back(mk(1,0,5,0,8'h00,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,8'h00,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(1,0,2,0,8'h00,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,8'h00,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(1,1,0,0,8'h00,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,8'h00,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(1,0,0,1,8'h03,3,1,0, 1,1,1,0,1));
    tbl.push_back(mk(1,0,3,0,8'h00,0,1,0, 0,1,1,1,1));
    rst_at = tbl.size();
    tbl.push_back(mk(1,0,0,0,8'h00,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(1,0,0,0,8'h00,0,1,0, 1,1,1,0,0));

    rst = 1'b1;
    drive(mk(0,0,0,0,8'h00,0,0,0, 0,0,0,0,0));
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == rst_at) mid_reset();
      step(tbl[i], i);
    end

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
